alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares the single combinational Alu between NUM_REQ requesters using round-robin arbitration.
- Latches the winner's operands and opcode into registers that drive the Alu.
- Captures the Alu result, carry-out and zero flag, then returns them with the requester ID over a valid/ready response channel.
- Sits between the issue logic and the Alu instance in the datapath.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_W, 32, operand/result width.
- SEL_W, 4, opcode width; opcodes pass through unchanged.
- ID_W, $clog2(NUM_REQ), derived localparam; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held until granted.
- req_a  in  NUM_REQ*DATA_W  packed operand A; slot i = requester i.
- req_b  in  NUM_REQ*DATA_W  packed operand B.
- req_sel  in  NUM_REQ*SEL_W  packed opcode.
- gnt  out  NUM_REQ  one-hot grant; operands accepted this edge.
- alu_a  out  DATA_W  registered operand A to Alu.
- alu_b  out  DATA_W  registered operand B to Alu.
- alu_sel  out  SEL_W  registered opcode to Alu.
- alu_out  in  DATA_W  Alu result.
- alu_cout  in  1  Alu carry-out (coutfin).
- alu_z  in  1  Alu zero flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  ID_W  index of the requester that issued the op.
- rsp_data  out  DATA_W  captured result.
- rsp_cout  out  1  captured carry.
- rsp_z  out  1  captured zero flag.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - gnt is combinational: one-hot to the first asserted req[i], searching from (last+1) mod NUM_REQ.
  - gnt is zero in every other state.
  - On a grant edge: alu_a/alu_b/alu_sel ← winner's slot; cur_id ← winner; last ← winner; go to EXEC.
  - No req: stay in IDLE; alu_* hold their values.
- EXEC (exactly 1 cycle): rsp_data/cout/z ← alu_out/alu_cout/alu_z; rsp_id ← cur_id; rsp_valid ← 1; go to RESP.
- RESP:
  - Hold all rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid ← 0; go to IDLE.
- Latency and throughput:
  - Response appears 2 edges after the grant edge.
  - Minimum issue interval is 3 cycles (rsp_ready tied high).
- Reset values: state IDLE, last = NUM_REQ-1 (requester 0 has first priority), all outputs 0.
- Boundary conditions:
  - req dropped before grant: no grant, no op.
  - req held by the same requester after its grant: treated as a new request next IDLE; round-robin still rotates to other requesters first.
  - All req high: grants strictly rotate 0,1,2,3,0…
  - rst during EXEC/RESP: in-flight op discarded, no response emitted, state IDLE next cycle.
  - Requester operands are sampled only on its grant edge; later changes are ignored.

Optional Feature:
- Macro: ALU_RR_ARBITER_STATS_EN.
- Defined:
  - Adds input stat_clr (1) and output stat_cnt (NUM_REQ*16).
  - Per-requester 16-bit saturating grant counters; each increments on its gnt bit and sticks at 16'hFFFF.
  - stat_clr zeroes all counters synchronously; it has priority over a same-cycle increment.
  - Reset clears the counters.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_arb_pkg:
  - state enum (IDLE/EXEC/RESP).
  - DATA_W/SEL_W defaults.
  - Stats counter width constant (16).
- Sub-module rr_picker:
  - Combinational round-robin one-hot picker.
  - Inputs: req vector, last index. Outputs: one-hot grant, winner index, any.

Test Plan:
- Reset, then req=4'b0001, A=32'hABCDEFFF, B=32'h12345678, sel=4'b0010, rsp_ready=1 → gnt=0001 in cycle 0; rsp_valid in cycle 2; rsp_id=0; rsp_data/cout/z equal a reference Alu instance given the same inputs.
- req=4'b1111 held, rsp_ready=1 → grant order 0,1,2,3,0 at 3-cycle spacing; rsp_id follows the same order.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_* stable; no gnt; one response accepted when ready rises.
- req[2] pulsed, then dropped before grant while req[1] wins → no op from requester 2, no response with id 2.
- rst asserted in EXEC with an op in flight → rsp_valid stays 0; all outputs 0 next cycle; requester 0 wins the next arbitration.
- With ALU_RR_ARBITER_STATS_EN: 8 ops across all four requesters → stat_cnt = 2 each; stat_clr → all 0; forced 65536 grants → count saturates at 16'hFFFF.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
//   Shared types and constants for the round-robin Alu arbiter slice.
//   - arb_state_e : arbiter FSM states (IDLE / EXEC / RESP)
//   - DATA_W_DEF  : default operand/result width
//   - SEL_W_DEF   : default opcode width
//   - STAT_W      : width of each per-requester grant counter (optional
//                   statistics, enabled by ALU_RR_ARBITER_STATS_EN)
// -----------------------------------------------------------------------------
package alu_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int SEL_W_DEF  = 4;
    localparam int STAT_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // waiting for a request, grant is live
        EXEC = 2'd1,  // operands registered, Alu settling
        RESP = 2'd2   // result held on the response channel
    } arb_state_e;

endpackage : alu_arb_pkg

// File: rtl/alu_rr_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin picker. Searches the request vector starting
//   one past the previous winner and wrapping around, and returns the first
//   asserted requester.
//
//   Ports
//     req   in  NUM_REQ  request vector
//     last  in  ID_W     index of the previous winner
//     gnt   out NUM_REQ  one-hot grant (all zero when nothing requests)
//     idx   out ID_W     index of the winner
//     any   out 1        at least one request is asserted
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    int unsigned cand;

    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        // Offset 1 first, offset NUM_REQ last: the previous winner is
        // considered only after every other requester.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last) + k) % NUM_REQ;
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = ID_W'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule : rr_picker

// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
//   Shares one combinational Alu between NUM_REQ requesters. A round-robin
//   winner's operands and opcode are registered onto alu_a/alu_b/alu_sel, the
//   Alu result is captured one cycle later and returned together with the
//   requester index on a valid/ready response channel.
//
//   Optional statistics (per-requester saturating grant counters) are built
//   when the macro ALU_RR_ARBITER_STATS_EN is defined.
//
//   Ports
//     clk        in  1               system clock, rising edge
//     rst        in  1               synchronous active-high reset
//     req        in  NUM_REQ         per-requester request, held until granted
//     req_a      in  NUM_REQ*DATA_W  packed operand A, slot i = requester i
//     req_b      in  NUM_REQ*DATA_W  packed operand B
//     req_sel    in  NUM_REQ*SEL_W   packed opcode
//     gnt        out NUM_REQ         one-hot grant, operands taken this edge
//     alu_a      out DATA_W          registered operand A to the Alu
//     alu_b      out DATA_W          registered operand B to the Alu
//     alu_sel    out SEL_W           registered opcode to the Alu
//     alu_out    in  DATA_W          Alu result
//     alu_cout   in  1               Alu carry-out
//     alu_z      in  1               Alu zero flag
//     rsp_valid  out 1               response valid
//     rsp_ready  in  1               consumer accepts response
//     rsp_id     out ID_W            requester that issued the op
//     rsp_data   out DATA_W          captured result
//     rsp_cout   out 1               captured carry
//     rsp_z      out 1               captured zero flag
//     stat_clr   in  1               (stats only) clear all grant counters
//     stat_cnt   out NUM_REQ*16      (stats only) packed grant counters
// -----------------------------------------------------------------------------
module alu_rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  DATA_W  = DATA_W_DEF,
    parameter int  SEL_W   = SEL_W_DEF,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [SEL_W-1:0]          alu_sel,
    input  logic [DATA_W-1:0]         alu_out,
    input  logic                      alu_cout,
    input  logic                      alu_z,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_cout,
    output logic                      rsp_z
`ifdef ALU_RR_ARBITER_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [NUM_REQ*STAT_W-1:0] stat_cnt
`endif
);

    arb_state_e          state_q;
    arb_state_e          state_d;
    logic [ID_W-1:0]     last_q;
    logic [ID_W-1:0]     cur_id_q;
    logic                accept;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;

    logic [DATA_W-1:0]   win_a;
    logic [DATA_W-1:0]   win_b;
    logic [SEL_W-1:0]    win_sel;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req  (req),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Winner's operand slot.
    always_comb begin
        win_a   = req_a[pick_idx*DATA_W +: DATA_W];
        win_b   = req_b[pick_idx*DATA_W +: DATA_W];
        win_sel = req_sel[pick_idx*SEL_W +: SEL_W];
    end

    // Next state and grant. The grant is masked while rst is high: the edge
    // that applies reset cannot accept operands, so no requester may be told
    // it was served.
    always_comb begin
        state_d = state_q;
        gnt     = '0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any && !rst) begin
                    gnt     = pick_gnt;
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= ID_W'(NUM_REQ - 1);
            cur_id_q  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_cout  <= 1'b0;
            rsp_z     <= 1'b0;
        end else begin
            state_q <= state_d;

            // Operands are taken only on the grant edge; the requester may
            // change or drop them afterwards.
            if (accept) begin
                alu_a    <= win_a;
                alu_b    <= win_b;
                alu_sel  <= win_sel;
                cur_id_q <= pick_idx;
                last_q   <= pick_idx;
            end

            // The Alu has had one full cycle to settle on the registered
            // operands; capture its outputs.
            if (state_q == EXEC) begin
                rsp_data  <= alu_out;
                rsp_cout  <= alu_cout;
                rsp_z     <= alu_z;
                rsp_id    <= cur_id_q;
                rsp_valid <= 1'b1;
            end

            if (state_q == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_RR_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] stat_q;

    // Clear wins over a same-cycle grant; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && (stat_q[i] != {STAT_W{1'b1}})) begin
                    stat_q[i] <= stat_q[i] + STAT_W'(1);
                end
            end
        end
    end

    assign stat_cnt = stat_q;
`endif

endmodule : alu_rr_arbiter

// File: tb/tb_alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_arbiter
//   Self-checking bench for alu_rr_arbiter. Each grant pushes the hand-computed
//   response for that requester into a queue; a monitor pops and compares
//   whenever a response is accepted. A behavioural Alu stands in for the real
//   one on the alu_* ports. Define ALU_RR_ARBITER_STATS_EN to also exercise
//   the grant counters.
// -----------------------------------------------------------------------------
module tb_alu_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 4;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] res;
        logic              cout;
        logic              z;
    } rsp_t;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              cout;
        logic              z;
    } alu_res_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*SEL_W-1:0]  req_sel;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [SEL_W-1:0]          alu_sel;
    logic [DATA_W-1:0]         alu_out;
    logic                      alu_cout;
    logic                      alu_z;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_cout;
    logic                      rsp_z;
`ifdef ALU_RR_ARBITER_STATS_EN
    logic                      stat_clr;
    logic [NUM_REQ*16-1:0]     stat_cnt;
`endif

    int   checks   = 0;
    int   errors   = 0;
    int   resp_cnt = 0;
    int   cyc      = 0;
    rsp_t exp_q[$];
    rsp_t vec_exp[NUM_REQ];
    rsp_t mon_e;
    alu_res_t alu_now;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_rr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .gnt       (gnt),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_cout  (alu_cout),
        .alu_z     (alu_z),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_cout  (rsp_cout),
        .rsp_z     (rsp_z)
`ifdef ALU_RR_ARBITER_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_cnt  (stat_cnt)
`endif
    );

    // Behavioural Alu: AND, OR, ADD, SUB, NOR; anything else is XOR.
    function automatic alu_res_t alu_model(input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b,
                                           input logic [SEL_W-1:0]  sel);
        logic [DATA_W:0] w;
        alu_res_t        r;
        case (sel)
            4'b0000: w = {1'b0, a & b};
            4'b0001: w = {1'b0, a | b};
            4'b0010: w = {1'b0, a} + {1'b0, b};
            4'b0110: w = {1'b0, a} + {1'b0, ~b} + 33'd1;
            4'b1100: w = {1'b0, ~(a | b)};
            default: w = {1'b0, a ^ b};
        endcase
        r.res  = w[DATA_W-1:0];
        r.cout = w[DATA_W];
        r.z    = (w[DATA_W-1:0] == '0);
        return r;
    endfunction

    always_comb alu_now = alu_model(alu_a, alu_b, alu_sel);
    assign alu_out  = alu_now.res;
    assign alu_cout = alu_now.cout;
    assign alu_z    = alu_now.z;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_slot(input int i, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b, input logic [SEL_W-1:0] sel);
        req_a[i*DATA_W +: DATA_W] = a;
        req_b[i*DATA_W +: DATA_W] = b;
        req_sel[i*SEL_W +: SEL_W] = sel;
    endtask

    task automatic load_vectors();
        set_slot(0, 32'hABCDEFFF, 32'h12345678, 4'b0010);
        set_slot(1, 32'hFFFFFFFF, 32'h00000001, 4'b0010);
        set_slot(2, 32'h0000F0F0, 32'h0000FF00, 4'b0000);
        set_slot(3, 32'h00000005, 32'h00000005, 4'b0110);
    endtask

    // Waits (bounded) for a grant, checks it names the expected requester and
    // pushes that requester's response. Returns at 1 time unit after the grant
    // edge, i.e. in the EXEC cycle.
    task automatic expect_grant(input int id, input int budget, output int gcyc);
        int n = 0;
        @(negedge clk);
        while (gnt == '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        gcyc = cyc;
        check("grant_seen", 64'(gnt != '0), 64'd1);
        if (gnt != '0) begin
            check("grant_onehot", 64'(gnt), 64'(1 << id));
            exp_q.push_back(vec_exp[id]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected_id", 64'(rsp_id), 64'hDEAD);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_id",   64'(rsp_id),   64'(mon_e.id));
                check("rsp_data", 64'(rsp_data), 64'(mon_e.res));
                check("rsp_cout", 64'(rsp_cout), 64'(mon_e.cout));
                check("rsp_z",    64'(rsp_z),    64'(mon_e.z));
            end
            resp_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int gc;
        int prev_gc;
        logic [NUM_REQ-1:0] gnt_acc;
        int exp_resp;

        // Hand-computed responses for the slot vectors loaded above.
        vec_exp[0] = '{id: 2'd0, res: 32'hBE024677, cout: 1'b0, z: 1'b0};
        vec_exp[1] = '{id: 2'd1, res: 32'h00000000, cout: 1'b1, z: 1'b1};
        vec_exp[2] = '{id: 2'd2, res: 32'h0000F000, cout: 1'b0, z: 1'b0};
        vec_exp[3] = '{id: 2'd3, res: 32'h00000000, cout: 1'b1, z: 1'b1};

        rst       = 1'b1;
        req       = '0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        rsp_ready = 1'b1;
`ifdef ALU_RR_ARBITER_STATS_EN
        stat_clr  = 1'b0;
`endif
        load_vectors();
        repeat (3) @(posedge clk);

        // ---- reset state ----
        @(negedge clk);
        check("rst_gnt",       64'(gnt),       64'd0);
        check("rst_alu_a",     64'(alu_a),     64'd0);
        check("rst_alu_sel",   64'(alu_sel),   64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data",  64'(rsp_data),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- single op from requester 0, latency and operand capture ----
        req = 4'b0001;
        expect_grant(0, 5, gc);
        req = 4'b0000;
        set_slot(0, 32'h0, 32'h0, 4'b0001);   // must not affect the op in flight
        @(negedge clk);
        check("lat_exec_valid", 64'(rsp_valid), 64'd0);
        check("op_alu_a",   64'(alu_a),   64'hABCDEFFF);
        check("op_alu_b",   64'(alu_b),   64'h12345678);
        check("op_alu_sel", 64'(alu_sel), 64'h2);
        @(negedge clk);
        check("lat_resp_valid", 64'(rsp_valid), 64'd1);
        load_vectors();
        drain(10);

        // ---- all requesting: strict rotation from a fresh reset ----
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'b1111;
        prev_gc = -1;
        for (int i = 0; i < 5; i++) begin
            expect_grant(i % NUM_REQ, 6, gc);
            if (prev_gc >= 0) check("grant_spacing", 64'(gc - prev_gc), 64'd3);
            prev_gc = gc;
        end
        req = 4'b0000;
        drain(10);

        // ---- backpressure: response held stable, no grant meanwhile ----
        rsp_ready = 1'b0;
        req = 4'b0100;
        expect_grant(2, 5, gc);
        req = 4'b1000;
        for (int n = 0; n < 5 && !rsp_valid; n++) @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_id",    64'(rsp_id),    64'd2);
            check("bp_data",  64'(rsp_data),  64'h0000F000);
            check("bp_gnt",   64'(gnt),       64'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        expect_grant(3, 6, gc);
        req = 4'b0000;
        drain(10);

        // ---- requester 2 drops its request after losing to requester 1 ----
        req = 4'b0110;
        expect_grant(1, 5, gc);
        req = 4'b0000;
        gnt_acc = '0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            gnt_acc = gnt_acc | gnt;
        end
        check("dropped_no_grant", 64'(gnt_acc), 64'd0);
        drain(10);

        // ---- reset with an op in flight ----
        req = 4'b1001;
        expect_grant(3, 5, gc);
        void'(exp_q.pop_back());               // this op is discarded by reset
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("inflight_rsp_valid", 64'(rsp_valid), 64'd0);
        check("inflight_alu_a",     64'(alu_a),     64'd0);
        check("inflight_alu_b",     64'(alu_b),     64'd0);
        check("inflight_rsp_data",  64'(rsp_data),  64'd0);
        check("inflight_rsp_z",     64'(rsp_z),     64'd0);
        check("inflight_gnt",       64'(gnt),       64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_grant(0, 5, gc);
        req = 4'b0000;
        drain(10);
        exp_resp = 10;

`ifdef ALU_RR_ARBITER_STATS_EN
        // ---- grant counters ----
        stat_clr = 1'b1;
        req = 4'b0001;
        expect_grant(0, 5, gc);               // clear beats the same-edge grant
        stat_clr = 1'b0;
        req = 4'b0000;
        @(negedge clk);
        check("stat_clr_priority", 64'(stat_cnt), 64'd0);
        drain(10);
        req = 4'b1111;
        for (int i = 0; i < 8; i++) expect_grant((1 + i) % NUM_REQ, 6, gc);
        req = 4'b0000;
        drain(10);
        check("stat_two_each", 64'(stat_cnt), 64'h0002_0002_0002_0002);
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        @(negedge clk);
        check("stat_cleared", 64'(stat_cnt), 64'd0);
        exp_resp = exp_resp + 9;
`endif

        repeat (4) @(negedge clk);
        check("resp_total", 64'(resp_cnt), 64'(exp_resp));
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_rr_arbiter
